// File: rtl/t00_pb_debouncer.sv
// t00_pb_debouncer: multi-channel pushbutton synchronizer and debouncer.
//
// Each channel runs a two-flop synchronizer and a debounce counter. A new
// level is accepted only after the synchronized input has differed from the
// current level for DEBOUNCE_CYCLES consecutive enabled cycles. On the edge
// that accepts it, the channel also registers a one-cycle rise or fall strobe.
//
// Ports:
//   clk      in   system clock
//   reset    in   asynchronous, active-high reset
//   en       in   enable; 0 holds the debounce state and gates the strobes to 0
//   pb_raw   in   [N_CH] raw buttons, asynchronous to clk
//   pb_level out  [N_CH] debounced level
//   pb_rise  out  [N_CH] one-cycle strobe on an accepted 0->1 (or auto-repeat)
//   pb_fall  out  [N_CH] one-cycle strobe on an accepted 1->0
//   any_rise out  OR of pb_rise
//
// Optional build macro T00_PB_AUTOREPEAT_EN: if it is defined, a held button
// re-strobes pb_rise after REPEAT_DELAY cycles and then every REPEAT_PERIOD
// cycles. If it is not defined, no repeat logic is built.

module t00_pb_debouncer_ch #(
  parameter int CNT_W           = 16,
  parameter int DEBOUNCE_CYCLES = 12000,
  parameter int REPEAT_DELAY    = 6000000,
  parameter int REPEAT_PERIOD   = 1200000
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic en_i,
  input  logic raw_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  // Parameter sanity, evaluated at elaboration only.
  if (DEBOUNCE_CYCLES < 1 || (64'd1 << CNT_W) <= 64'(DEBOUNCE_CYCLES) ||
      REPEAT_PERIOD < 1 || REPEAT_DELAY < REPEAT_PERIOD) begin : g_bad_param
    $error("t00_pb_debouncer_ch: illegal parameter combination");
  end

  logic             s1_q, s2_q;
  logic             lvl_q, lvl_d;
  logic             rise_q, rise_d, fall_q, fall_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             accept;

  // The counter has already seen DEBOUNCE_CYCLES-1 mismatching cycles, so
  // this mismatching cycle completes the window.
  assign accept = en_i && (s2_q != lvl_q) && (cnt_q == CNT_LAST);

  always_comb begin
    cnt_d = cnt_q;
    lvl_d = lvl_q;
    if (en_i) begin
      if (s2_q == lvl_q) begin
        cnt_d = '0;
      end else if (accept) begin
        cnt_d = '0;
        lvl_d = s2_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

`ifdef T00_PB_AUTOREPEAT_EN
  localparam int            RW       = $clog2(REPEAT_DELAY + 1);
  localparam logic [RW-1:0] R_FIRE   = RW'(REPEAT_DELAY - 1);
  // After a repeat fires, reload so that the next fire is REPEAT_PERIOD later.
  localparam logic [RW-1:0] R_RELOAD = RW'(REPEAT_DELAY - REPEAT_PERIOD);

  logic [RW-1:0] rcnt_q, rcnt_d;
  logic          rep_fire;

  // rcnt counts enabled cycles after the rise edge. A level change that is
  // accepted on this edge always takes priority over a repeat.
  assign rep_fire = en_i && lvl_q && !accept && (rcnt_q == R_FIRE);

  always_comb begin
    rcnt_d = rcnt_q;
    if (!lvl_q || accept) rcnt_d = '0;
    else if (en_i)        rcnt_d = rep_fire ? R_RELOAD : rcnt_q + 1'b1;
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) rcnt_q <= '0;
    else         rcnt_q <= rcnt_d;
  end

  assign rise_d = (accept && s2_q) || rep_fire;
`else
  assign rise_d = accept && s2_q;
`endif
  assign fall_d = accept && !s2_q;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      s1_q   <= 1'b0;
      s2_q   <= 1'b0;
      lvl_q  <= 1'b0;
      cnt_q  <= '0;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      s1_q   <= raw_i;
      s2_q   <= s1_q;
      lvl_q  <= lvl_d;
      cnt_q  <= cnt_d;
      rise_q <= rise_d;
      fall_q <= fall_d;
    end
  end

  assign level_o = lvl_q;
  // A strobe registered just before en drops must not leak out.
  assign rise_o  = rise_q && en_i;
  assign fall_o  = fall_q && en_i;
endmodule

module t00_pb_debouncer #(
  parameter int N_CH            = 21,
  parameter int CNT_W           = 16,
  parameter int DEBOUNCE_CYCLES = 12000,
  parameter int REPEAT_DELAY    = 6000000,
  parameter int REPEAT_PERIOD   = 1200000
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            en,
  input  logic [N_CH-1:0] pb_raw,
  output logic [N_CH-1:0] pb_level,
  output logic [N_CH-1:0] pb_rise,
  output logic [N_CH-1:0] pb_fall,
  output logic            any_rise
);
  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    t00_pb_debouncer_ch #(
      .CNT_W          (CNT_W),
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .REPEAT_DELAY   (REPEAT_DELAY),
      .REPEAT_PERIOD  (REPEAT_PERIOD)
    ) u_ch (
      .clk_i  (clk),
      .reset_i(reset),
      .en_i   (en),
      .raw_i  (pb_raw[g]),
      .level_o(pb_level[g]),
      .rise_o (pb_rise[g]),
      .fall_o (pb_fall[g])
    );
  end

  assign any_rise = |pb_rise;
endmodule

// File: tb/tb_t00_pb_debouncer.sv
// Testbench for t00_pb_debouncer: directed scenario tasks, followed by a
// randomized run that is checked against a window-based reference model.
module tb_t00_pb_debouncer;
  localparam int N  = 4;
  localparam int D  = 4;
  localparam int RD = 10;
  localparam int RP = 3;

  logic         clk = 1'b0;
  logic         reset, en;
  logic [N-1:0] pb_raw, pb_level, pb_rise, pb_fall;
  logic         any_rise;
  int           n_tests = 0;
  int           n_fail  = 0;

  t00_pb_debouncer #(.N_CH(N), .CNT_W(4), .DEBOUNCE_CYCLES(D),
                     .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)) dut (
    .clk(clk), .reset(reset), .en(en), .pb_raw(pb_raw),
    .pb_level(pb_level), .pb_rise(pb_rise), .pb_fall(pb_fall),
    .any_rise(any_rise));

  always #5 clk = ~clk;

  // Reference model. The level flips once the last D enabled synchronized
  // samples all disagree with it. Repeat strobes are derived from the number
  // of enabled cycles held high since the rise.
  logic [N-1:0] m_s1, m_s2, m_lvl, m_rise, m_fall;
  bit           hq [N][$];
  int           m_h [N];

  always @(posedge clk or posedge reset) begin : mdl
    logic [N-1:0] l_lvl, l_rise, l_fall;
    bit           all_opp;
    if (reset) begin
      m_s1 <= '0; m_s2 <= '0; m_lvl <= '0; m_rise <= '0; m_fall <= '0;
      for (int c = 0; c < N; c++) begin hq[c].delete(); m_h[c] = 0; end
    end else begin
      l_lvl = m_lvl; l_rise = '0; l_fall = '0;
      for (int c = 0; c < N; c++) begin
        if (en) begin
          hq[c].push_back(m_s2[c]);
          if (hq[c].size() > D) void'(hq[c].pop_front());
          all_opp = (hq[c].size() == D);
          foreach (hq[c][i]) if (hq[c][i] == l_lvl[c]) all_opp = 1'b0;
          if (all_opp) begin
            l_lvl[c] = ~l_lvl[c];
            if (l_lvl[c]) l_rise[c] = 1'b1; else l_fall[c] = 1'b1;
            m_h[c] = 0;
            hq[c].delete();
          end else if (l_lvl[c]) begin
            m_h[c] = m_h[c] + 1;
`ifdef T00_PB_AUTOREPEAT_EN
            if (m_h[c] >= RD && (m_h[c] - RD) % RP == 0) l_rise[c] = 1'b1;
`endif
          end else begin
            m_h[c] = 0;
          end
        end
      end
      m_lvl <= l_lvl; m_rise <= l_rise; m_fall <= l_fall;
      m_s2 <= m_s1; m_s1 <= pb_raw;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic step(input int n);
    repeat (n) begin @(posedge clk); @(negedge clk); end
  endtask

  task automatic test_reset;
    reset = 1'b1; en = 1'b1; pb_raw = '0;
    step(2);
    n_tests++;
    if ({pb_level, pb_rise, pb_fall, any_rise} !== 13'd0) begin
      n_fail++;
      $display("FAIL reset_state: actual lvl=%b rise=%b fall=%b any=%b required all 0",
               pb_level, pb_rise, pb_fall, any_rise);
    end
    reset = 1'b0;
    step(1);
  endtask

  task automatic test_clean_press;
    pb_raw[0] = 1'b1;
    step(5);
    n_tests++;
    if (pb_level !== 4'b0000 || pb_rise !== 4'b0000) begin
      n_fail++;
      $display("FAIL clean_early: actual lvl=%b rise=%b required 0000/0000", pb_level, pb_rise);
    end
    step(1);
    n_tests++;
    if (pb_level !== 4'b0001 || pb_rise !== 4'b0001 || any_rise !== 1'b1 || pb_fall !== 4'b0) begin
      n_fail++;
      $display("FAIL clean_edge: actual lvl=%b rise=%b fall=%b any=%b required 0001/0001/0000/1",
               pb_level, pb_rise, pb_fall, any_rise);
    end
    step(1);
    n_tests++;
    if (pb_level !== 4'b0001 || pb_rise !== 4'b0000) begin
      n_fail++;
      $display("FAIL clean_after: actual lvl=%b rise=%b required 0001/0000", pb_level, pb_rise);
    end
  endtask

  task automatic test_bounce;
    for (int i = 0; i < 4; i++) begin
      pb_raw[1] = (i % 2 == 0);
      for (int k = 0; k < 2; k++) begin
        step(1);
        n_tests++;
        if (pb_rise[1] !== 1'b0 || pb_level[1] !== 1'b0) begin
          n_fail++;
          $display("FAIL bounce_quiet: actual lvl1=%b rise1=%b required 0/0", pb_level[1], pb_rise[1]);
        end
      end
    end
    pb_raw[1] = 1'b1;
    step(5);
    n_tests++;
    if (pb_rise[1] !== 1'b0 || pb_level[1] !== 1'b0) begin
      n_fail++;
      $display("FAIL bounce_early: actual lvl1=%b rise1=%b required 0/0", pb_level[1], pb_rise[1]);
    end
    step(1);
    n_tests++;
    if (pb_rise[1] !== 1'b1 || pb_level[1] !== 1'b1) begin
      n_fail++;
      $display("FAIL bounce_edge: actual lvl1=%b rise1=%b required 1/1", pb_level[1], pb_rise[1]);
    end
    step(1);
    n_tests++;
    if (pb_rise[1] !== 1'b0) begin
      n_fail++;
      $display("FAIL bounce_single: actual rise1=%b required 0", pb_rise[1]);
    end
  endtask

  task automatic test_glitch;
    pb_raw[2] = 1'b1;
    step(8);
    n_tests++;
    if (pb_level[2] !== 1'b1) begin
      n_fail++;
      $display("FAIL glitch_setup: actual lvl2=%b required 1", pb_level[2]);
    end
    pb_raw[2] = 1'b0;
    step(3);
    pb_raw[2] = 1'b1;
    for (int k = 0; k < 10; k++) begin
      step(1);
      n_tests++;
      if (pb_level[2] !== 1'b1 || pb_fall[2] !== 1'b0) begin
        n_fail++;
        $display("FAIL glitch_reject: actual lvl2=%b fall2=%b required 1/0", pb_level[2], pb_fall[2]);
      end
    end
  endtask

  task automatic test_enable_freeze;
    pb_raw[2] = 1'b0;
    step(4);
    en = 1'b0;
    for (int k = 0; k < 10; k++) begin
      step(1);
      n_tests++;
      if (pb_level[2] !== 1'b1 || pb_fall !== 4'b0 || pb_rise !== 4'b0 || any_rise !== 1'b0) begin
        n_fail++;
        $display("FAIL freeze_hold: actual lvl2=%b fall=%b rise=%b any=%b required 1/0000/0000/0",
                 pb_level[2], pb_fall, pb_rise, any_rise);
      end
    end
    en = 1'b1;
    step(1);
    n_tests++;
    if (pb_level[2] !== 1'b1 || pb_fall[2] !== 1'b0) begin
      n_fail++;
      $display("FAIL freeze_resume1: actual lvl2=%b fall2=%b required 1/0", pb_level[2], pb_fall[2]);
    end
    step(1);
    n_tests++;
    if (pb_level[2] !== 1'b0 || pb_fall[2] !== 1'b1) begin
      n_fail++;
      $display("FAIL freeze_resume2: actual lvl2=%b fall2=%b required 0/1", pb_level[2], pb_fall[2]);
    end
    step(1);
    n_tests++;
    if (pb_fall[2] !== 1'b0) begin
      n_fail++;
      $display("FAIL freeze_single: actual fall2=%b required 0", pb_fall[2]);
    end
  endtask

  task automatic test_reset_mid;
    pb_raw[1] = 1'b0;
    step(5);
    n_tests++;
    if (pb_level[1] !== 1'b1 || pb_fall[1] !== 1'b0) begin
      n_fail++;
      $display("FAIL rstmid_setup: actual lvl1=%b fall1=%b required 1/0", pb_level[1], pb_fall[1]);
    end
    reset = 1'b1;
    #1;
    n_tests++;
    if ({pb_level, pb_rise, pb_fall, any_rise} !== 13'd0) begin
      n_fail++;
      $display("FAIL rstmid_async: actual lvl=%b rise=%b fall=%b any=%b required all 0",
               pb_level, pb_rise, pb_fall, any_rise);
    end
    step(1);
    reset = 1'b0;
    step(5);
    n_tests++;
    if (pb_level !== 4'b0000 || pb_rise !== 4'b0000 || pb_fall !== 4'b0000) begin
      n_fail++;
      $display("FAIL rstmid_early: actual lvl=%b rise=%b fall=%b required 0000", pb_level, pb_rise, pb_fall);
    end
    step(1);
    n_tests++;
    if (pb_level !== 4'b0001 || pb_rise !== 4'b0001) begin
      n_fail++;
      $display("FAIL rstmid_rise: actual lvl=%b rise=%b required 0001/0001", pb_level, pb_rise);
    end
  endtask

  task automatic test_autorepeat;
    logic exp;
    pb_raw[3] = 1'b1;
    step(5);
    n_tests++;
    if (pb_rise[3] !== 1'b0) begin
      n_fail++;
      $display("FAIL rep_early: actual rise3=%b required 0", pb_rise[3]);
    end
    step(1);
    n_tests++;
    if (pb_rise[3] !== 1'b1 || pb_level[3] !== 1'b1) begin
      n_fail++;
      $display("FAIL rep_first: actual lvl3=%b rise3=%b required 1/1", pb_level[3], pb_rise[3]);
    end
    for (int k = 1; k < 30; k++) begin
      if (k == 25) pb_raw[3] = 1'b0;
      step(1);
`ifdef T00_PB_AUTOREPEAT_EN
      exp = (k >= RD && (k - RD) % RP == 0);
`else
      exp = 1'b0;
`endif
      n_tests++;
      if (pb_rise[3] !== exp || pb_level[3] !== 1'b1) begin
        n_fail++;
        $display("FAIL rep_hold k=%0d: actual rise3=%b lvl3=%b required %b/1", k, pb_rise[3], pb_level[3], exp);
      end
    end
    step(1);
    n_tests++;
    if (pb_fall[3] !== 1'b1 || pb_rise[3] !== 1'b0 || pb_level[3] !== 1'b0) begin
      n_fail++;
      $display("FAIL rep_release: actual fall3=%b rise3=%b lvl3=%b required 1/0/0",
               pb_fall[3], pb_rise[3], pb_level[3]);
    end
    for (int k = 0; k < 8; k++) begin
      step(1);
      n_tests++;
      if (pb_fall[3] !== 1'b0 || pb_rise[3] !== 1'b0) begin
        n_fail++;
        $display("FAIL rep_quiet: actual fall3=%b rise3=%b required 0/0", pb_fall[3], pb_rise[3]);
      end
    end
  endtask

  task automatic test_random;
    logic [N-1:0] er, ef;
    for (int cyc = 0; cyc < 400; cyc++) begin
      for (int c = 0; c < N; c++)
        if ($urandom_range(0, 5) == 0) pb_raw[c] = ~pb_raw[c];
      en = ($urandom_range(0, 9) != 0);
      step(1);
      er = en ? m_rise : '0;
      ef = en ? m_fall : '0;
      n_tests++;
      if (pb_level !== m_lvl || pb_rise !== er || pb_fall !== ef || any_rise !== (|er)) begin
        n_fail++;
        $display("FAIL random cyc=%0d: actual lvl=%b rise=%b fall=%b any=%b required %b/%b/%b/%b",
                 cyc, pb_level, pb_rise, pb_fall, any_rise, m_lvl, er, ef, |er);
      end
    end
  endtask

  initial begin
    test_reset();
    test_clean_press();
    test_bounce();
    test_glitch();
    test_enable_freeze();
    test_reset_mid();
    test_autorepeat();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
